// File: rtl/scan_sequencer.sv
// 8-position scan sequencer: prescaled idx stepping, single/continuous sweep, up/down; all outputs registered.
// Optional SCAN_HOLD_EN adds a hold input that freezes stepping while RUN continues.
module scan_sequencer #(
    parameter int DIV_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 stop,
    input  logic                 mode_cont,
    input  logic                 dir_down,
`ifdef SCAN_HOLD_EN
    input  logic                 hold,
`endif
    input  logic [DIV_WIDTH-1:0] div,
    output logic [2:0]           idx,
    output logic                 busy,
    output logic                 tick,
    output logic                 done
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [2:0]           idx_q, idx_d;
    logic                 busy_q, busy_d;
    logic                 tick_q, tick_d;
    logic                 done_q, done_d;
    logic [DIV_WIDTH-1:0] presc_q, presc_d;
    logic [DIV_WIDTH-1:0] div_q, div_d;
    logic                 cont_q, cont_d;
    logic                 down_q, down_d;
    logic                 hold_w;
    logic                 at_last;

`ifdef SCAN_HOLD_EN
    assign hold_w = hold;
`else
    assign hold_w = 1'b0;
`endif

    assign at_last = down_q ? (idx_q == 3'd0) : (idx_q == 3'd7);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        busy_d  = busy_q;
        tick_d  = 1'b0;
        done_d  = 1'b0;
        presc_d = presc_q;
        div_d   = div_q;
        cont_d  = cont_q;
        down_d  = down_q;
        case (state_q)
            IDLE: begin
                if (start && !stop) begin
                    state_d = RUN;
                    busy_d  = 1'b1;
                    cont_d  = mode_cont;
                    down_d  = dir_down;
                    div_d   = div;
                    idx_d   = dir_down ? 3'd7 : 3'd0;
                    presc_d = '0;
                end
            end
            RUN: begin
                if (stop) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end else if (!hold_w) begin
                    if (presc_q == div_q) begin
                        presc_d = '0;
                        // The final dwell of a single sweep ends the scan instead of advancing.
                        if (!cont_q && at_last) begin
                            state_d = IDLE;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                        end else begin
                            tick_d = 1'b1;
                            idx_d  = down_q ? (idx_q - 3'd1) : (idx_q + 3'd1);
                        end
                    end else begin
                        presc_d = presc_q + DIV_WIDTH'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= 3'd0;
            busy_q  <= 1'b0;
            tick_q  <= 1'b0;
            done_q  <= 1'b0;
            presc_q <= '0;
            div_q   <= '0;
            cont_q  <= 1'b0;
            down_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            busy_q  <= busy_d;
            tick_q  <= tick_d;
            done_q  <= done_d;
            presc_q <= presc_d;
            div_q   <= div_d;
            cont_q  <= cont_d;
            down_q  <= down_d;
        end
    end

    assign idx  = idx_q;
    assign busy = busy_q;
    assign tick = tick_q;
    assign done = done_q;

endmodule

// File: tb/tb_scan_sequencer.sv
// Directed and randomized bench for scan_sequencer against an elapsed-time reference model.
module tb_scan_sequencer;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic          mode_cont = 1'b0;
    logic          dir_down = 1'b0;
    logic          hold = 1'b0;
    logic [DW-1:0] div = '0;
    logic [2:0]    idx;
    logic          busy, tick, done;

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    // Reference model: position derived from active cycles elapsed since start.
    bit         m_run, m_cont, m_down, m_tick, m_done;
    int         m_d, m_n;
    logic [2:0] m_idx;

    scan_sequencer #(.DIV_WIDTH(DW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .stop      (stop),
        .mode_cont (mode_cont),
        .dir_down  (dir_down),
`ifdef SCAN_HOLD_EN
        .hold      (hold),
`endif
        .div       (div),
        .idx       (idx),
        .busy      (busy),
        .tick      (tick),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s cycle=%0d observed=%0d expected=%0d", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_run = 0; m_cont = 0; m_down = 0; m_tick = 0; m_done = 0;
        m_d = 0; m_n = 0; m_idx = 3'd0;
    endtask

    task automatic model_edge();
        int k;
        bit hd;
`ifdef SCAN_HOLD_EN
        hd = hold;
`else
        hd = 0;
`endif
        m_tick = 0;
        m_done = 0;
        if (!rst_n) begin
            model_reset();
        end else if (!m_run) begin
            if (start && !stop) begin
                m_run  = 1;
                m_d    = int'(div);
                m_down = dir_down;
                m_cont = mode_cont;
                m_n    = 0;
                m_idx  = m_down ? 3'd7 : 3'd0;
            end
        end else if (stop) begin
            m_run = 0;
        end else if (!hd) begin
            m_n++;
            if (m_n % (m_d + 1) == 0) begin
                k = m_n / (m_d + 1);
                if (!m_cont && k == 8) begin
                    m_run  = 0;
                    m_done = 1;
                end else begin
                    m_tick = 1;
                    m_idx  = 3'(m_down ? 7 - (k % 8) : k % 8);
                end
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        cyc++;
        model_edge();
        #1;
        chk("idx",  idx,  m_idx);
        chk("busy", busy, m_run);
        chk("tick", tick, m_tick);
        chk("done", done, m_done);
    endtask

    initial begin
        int ntick, ndone, done_at, c;
        logic [2:0] dn_seq [10];
        dn_seq = '{3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd7, 3'd6, 3'd5};
        model_reset();

        // Reset state
        repeat (2) step();
        rst_n = 1'b1;
        step();

        // Single up sweep, div=2
        div = 2; mode_cont = 0; dir_down = 0; start = 1;
        step();
        start = 0;
        ntick = 0; ndone = 0; done_at = -1;
        for (int i = 1; i <= 30; i++) begin
            step();
            if (tick) ntick++;
            if (done) begin
                ndone++;
                if (done_at < 0) done_at = i;
            end
        end
        chk("sweep_ticks", ntick, 7);
        chk("sweep_done_cycle", done_at, 24);
        chk("sweep_done_count", ndone, 1);
        chk("sweep_final_idx", idx, 7);
        chk("sweep_final_busy", busy, 0);

        // Continuous down wrap, div=0
        div = 0; mode_cont = 1; dir_down = 1; start = 1;
        step();
        start = 0;
        chk("down_first_idx", idx, 7);
        for (int i = 0; i < 10; i++) begin
            step();
            chk("down_seq_idx", idx, dn_seq[i]);
            chk("down_seq_tick", tick, 1);
            chk("down_seq_done", done, 0);
        end
        stop = 1; step(); stop = 0;

        // Stop at idx=3, div=4
        div = 4; mode_cont = 0; dir_down = 0; start = 1;
        step();
        start = 0;
        for (c = 0; c < 100 && idx != 3'd3; c++) step();
        chk("reach_idx3", idx, 3);
        stop = 1; step(); stop = 0;
        chk("stop_idx", idx, 3);
        chk("stop_busy", busy, 0);
        chk("stop_done", done, 0);
        repeat (3) step();

        // start and stop together in IDLE
        start = 1; stop = 1;
        repeat (3) step();
        chk("startstop_busy", busy, 0);
        start = 0; stop = 0;

        // Config freeze mid-scan
        div = 2; mode_cont = 0; dir_down = 0; start = 1;
        step();
        start = 0;
        step();
        div = 9; dir_down = 1;
        repeat (8) step();
        chk("freeze_idx", idx, 3);
        stop = 1; step(); stop = 0;

        // start held high through done restarts on the first IDLE cycle
        div = 0; mode_cont = 0; dir_down = 0; start = 1;
        repeat (9) step();
        chk("held_done", done, 1);
        step();
        chk("held_restart_busy", busy, 1);
        chk("held_restart_idx", idx, 0);
        start = 0; stop = 1; step(); stop = 0;

        // Asynchronous reset mid-scan at idx=5
        div = 1; mode_cont = 1; dir_down = 0; start = 1;
        step();
        start = 0;
        for (c = 0; c < 100 && idx != 3'd5; c++) step();
        chk("reach_idx5", idx, 5);
        #2 rst_n = 0;
        #1;
        model_reset();
        chk("arst_idx", idx, 0);
        chk("arst_busy", busy, 0);
        chk("arst_tick", tick, 0);
        chk("arst_done", done, 0);
        repeat (3) step();
        #2 rst_n = 1;
        repeat (2) step();

`ifdef SCAN_HOLD_EN
        // Hold for 5 cycles at idx=2, then resume
        div = 3; mode_cont = 0; dir_down = 0; start = 1;
        step();
        start = 0;
        for (c = 0; c < 100 && idx != 3'd2; c++) step();
        step();
        hold = 1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("hold_idx", idx, 2);
            chk("hold_tick", tick, 0);
        end
        hold = 0;
        repeat (12) step();
        stop = 1; step(); stop = 0;
`endif

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            start     = ($urandom_range(0, 3) == 0);
            stop      = ($urandom_range(0, 39) == 0);
            mode_cont = 1'($urandom_range(0, 1));
            dir_down  = 1'($urandom_range(0, 1));
            div       = DW'($urandom_range(0, 4));
            hold      = ($urandom_range(0, 4) == 0);
            rst_n     = ($urandom_range(0, 499) != 0);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
